seletor_bebida: RTL and testbench
=================================

SELETOR_BEBIDA -- requirements
Module: seletor_bebida

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required before a button level is accepted.
REQ-002 Parameter NUM_BEBIDAS, default 6, legal range 2..8: number of selectable drink codes, 0..NUM_BEBIDAS-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: idle cycles in SELECAO before automatic abandon.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_avancar  input  1  raw, asynchronous, bouncing "next drink" button; 1 = pressed.
REQ-007 btn_confirmar  input  1  raw "confirm order" button; 1 = pressed.
REQ-008 btn_cancelar  input  1  raw "cancel" button; 1 = pressed.
REQ-009 ack  input  1  order-consumer acknowledge; sampled only in PEDIDO.
REQ-010 x, y, z  output  1 each  registered drink code; x = MSB, z = LSB; feeds the drink display decoder.
REQ-011 entrada  output  1  display source select; 1 = drink view, 0 = sensor view.
REQ-012 pedido_valido  output  1  order request; high only in PEDIDO.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer; a debounced level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; release generates no event; a held button generates exactly one event.
REQ-015 Press latency: raw input stable high from cycle N SHALL produce a pulse in cycle N+2+DEB_CYCLES (+/-1 for async sampling); glitches shorter than DEB_CYCLES SHALL produce no event.
REQ-016 FSM states: OCIOSO, SELECAO, PEDIDO.
REQ-017 OCIOSO: entrada=0, pedido_valido=0; avancar event -> SELECAO with code=0; confirmar/cancelar events ignored.
REQ-018 SELECAO: entrada=1; avancar increments code, NUM_BEBIDAS-1 wraps to 0; confirmar -> PEDIDO; cancelar -> OCIOSO with code=0.
REQ-019 Simultaneous events in the same cycle: priority cancelar > confirmar > avancar; lower-priority events that cycle are discarded.
REQ-020 SELECAO inactivity counter SHALL clear on any event and on entry; reaching TIMEOUT_CYCLES SHALL move to OCIOSO with code=0.
REQ-021 PEDIDO: entrada=1, pedido_valido=1, code frozen; all button events discarded; pedido_valido SHALL stay high until ack=1 is sampled.
REQ-022 ack=1 in PEDIDO -> OCIOSO next cycle, pedido_valido=0, code=0; ack outside PEDIDO has no effect.
REQ-023 All outputs SHALL be registered; state change and output change occur on the same clock edge.
REQ-024 Code register width 3 bits; values >= NUM_BEBIDAS SHALL never appear.

Reset
REQ-025 reset=1 SHALL immediately force state OCIOSO, x=y=z=0, entrada=0, pedido_valido=0, clear debounced levels, debounce and timeout counters, and synchronizers.
REQ-026 Reset asserted mid-order (PEDIDO) or mid-debounce SHALL drop the pending order and event; a button still held at deassertion SHALL register as a new press after REQ-015 latency.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding (OCIOSO, SELECAO, PEDIDO), code width constant (3) and default DEB_CYCLES/TIMEOUT_CYCLES values.
REQ-028 Debounce + synchronizer + edge detect SHALL be one sub-module, debounce_botao, instantiated three times; FSM, code counter and timeout counter live in seletor_bebida.

Verification (DEB_CYCLES=4, NUM_BEBIDAS=6, TIMEOUT_CYCLES=32)
REQ-029 Reset, then btn_avancar high 20 cycles -> entrada=1, xyz=000 after ~6 cycles; one event only.
REQ-030 From SELECAO, 7 clean avancar presses -> codes 001,010,011,100,101,000,001 (wrap at 6).
REQ-031 avancar with 3-cycle glitches, 10 repetitions -> code unchanged, no event.
REQ-032 Select code 011, press confirmar -> pedido_valido=1, xyz=011 held for 50 cycles with no ack while avancar is pressed; ack=1 -> OCIOSO, pedido_valido=0, xyz=000.
REQ-033 confirmar and cancelar pressed in the same cycle in SELECAO -> OCIOSO, no pedido_valido; separately, no presses for 32 cycles in SELECAO -> OCIOSO.
REQ-034 reset asserted in PEDIDO -> all outputs 0 asynchronously before the next edge; later ack ignored.

Source files
------------

// File: rtl/seletor_bebida_pkg.sv
// Shared definitions for the drink selector: FSM encoding, code width and default timings.
package seletor_bebida_pkg;

  typedef enum logic [1:0] {
    Ocioso  = 2'd0,
    Selecao = 2'd1,
    Pedido  = 2'd2
  } estado_t;

  localparam int unsigned CODE_W             = 3;
  localparam int unsigned DEB_CYCLES_DEF     = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/debounce_botao.sv
// Button conditioner: 2-flop synchronizer, level debouncer and one-cycle press pulse.
module debounce_botao
  import seletor_bebida_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evento
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [1:0]      sync_q;
  logic            nivel_q, nivel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            evento_q, evento_d;

  // The counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    nivel_d  = nivel_q;
    cnt_d    = '0;
    evento_d = 1'b0;
    if (sync_q[1] != nivel_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        nivel_d  = sync_q[1];
        evento_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      nivel_q  <= 1'b0;
      cnt_q    <= '0;
      evento_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      nivel_q  <= nivel_d;
      cnt_q    <= cnt_d;
      evento_q <= evento_d;
    end
  end

  assign evento = evento_q;

endmodule

// File: rtl/seletor_bebida.sv
// Drink selector: browse drink codes with debounced buttons and hand an order to a consumer.
module seletor_bebida
  import seletor_bebida_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned NUM_BEBIDAS    = 6,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_avancar,
  input  logic btn_confirmar,
  input  logic btn_cancelar,
  input  logic ack,
  output logic x,
  output logic y,
  output logic z,
  output logic entrada,
  output logic pedido_valido
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic ev_avancar, ev_confirmar, ev_cancelar;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_avancar (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_avancar),
    .evento (ev_avancar)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_confirmar (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_confirmar),
    .evento (ev_confirmar)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancelar (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_cancelar),
    .evento (ev_cancelar)
  );

  estado_t           estado_q, estado_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              entrada_q, pedido_q;

  always_comb begin
    estado_d = estado_q;
    code_d   = code_q;
    tmo_d    = tmo_q;
    unique case (estado_q)
      Ocioso: begin
        tmo_d = '0;
        if (ev_avancar) begin
          estado_d = Selecao;
          code_d   = '0;
        end
      end
      Selecao: begin
        if (ev_cancelar) begin
          estado_d = Ocioso;
          code_d   = '0;
          tmo_d    = '0;
        end else if (ev_confirmar) begin
          estado_d = Pedido;
          tmo_d    = '0;
        end else if (ev_avancar) begin
          code_d = (code_q == CODE_W'(NUM_BEBIDAS - 1)) ? '0 : code_q + CODE_W'(1);
          tmo_d  = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          estado_d = Ocioso;
          code_d   = '0;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      Pedido: begin
        // Code stays frozen and buttons are ignored until the consumer takes the order.
        if (ack) begin
          estado_d = Ocioso;
          code_d   = '0;
        end
      end
      default: begin
        estado_d = Ocioso;
        code_d   = '0;
        tmo_d    = '0;
      end
    endcase
  end

  // Outputs are flopped from next-state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= Ocioso;
      code_q    <= '0;
      tmo_q     <= '0;
      entrada_q <= 1'b0;
      pedido_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      code_q    <= code_d;
      tmo_q     <= tmo_d;
      entrada_q <= (estado_d != Ocioso);
      pedido_q  <= (estado_d == Pedido);
    end
  end

  assign x             = code_q[2];
  assign y             = code_q[1];
  assign z             = code_q[0];
  assign entrada       = entrada_q;
  assign pedido_valido = pedido_q;

endmodule

// File: tb/tb_seletor_bebida.sv
// Directed self-checking bench for seletor_bebida with short debounce and timeout.
module tb_seletor_bebida;

  logic clk = 1'b0;
  logic reset;
  logic btn_avancar, btn_confirmar, btn_cancelar, ack;
  logic x, y, z, entrada, pedido_valido;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seletor_bebida #(
    .DEB_CYCLES     (4),
    .NUM_BEBIDAS    (6),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_avancar   (btn_avancar),
    .btn_confirmar (btn_confirmar),
    .btn_cancelar  (btn_cancelar),
    .ack           (ack),
    .x             (x),
    .y             (y),
    .z             (z),
    .entrada       (entrada),
    .pedido_valido (pedido_valido)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_avancar = v;
      1: btn_confirmar = v;
      default: btn_cancelar = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(12);
    set_btn(b, 1'b0);
    step(12);
  endtask

  logic [2:0] exp_codes [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
  logic       seen;

  initial begin
    reset = 1'b1;
    btn_avancar = 1'b0; btn_confirmar = 1'b0; btn_cancelar = 1'b0; ack = 1'b0;
    step(3);
    check("reset_entrada", {31'd0, entrada}, 32'd0);
    check("reset_pedido", {31'd0, pedido_valido}, 32'd0);
    check("reset_code", {29'd0, x, y, z}, 32'd0);
    reset = 1'b0;
    step(2);

    // Held avancar: pulse lands ~7 edges after the press, only once.
    btn_avancar = 1'b1;
    step(4);
    check("latency_early", {31'd0, entrada}, 32'd0);
    step(16);
    check("hold_entrada", {31'd0, entrada}, 32'd1);
    check("hold_code_once", {29'd0, x, y, z}, 32'd0);
    btn_avancar = 1'b0;
    step(12);
    check("release_no_event", {29'd0, x, y, z}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      press(0);
      check($sformatf("wrap_code_%0d", i), {29'd0, x, y, z}, {29'd0, exp_codes[i]});
    end

    // From 001 to 011, then confirm.
    press(0);
    press(0);
    check("sel_code_3", {29'd0, x, y, z}, 32'd3);
    press(1);
    check("pedido_valido", {31'd0, pedido_valido}, 32'd1);
    check("pedido_code", {29'd0, x, y, z}, 32'd3);
    btn_avancar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(10);
      check($sformatf("pedido_hold_pv_%0d", i), {31'd0, pedido_valido}, 32'd1);
      check($sformatf("pedido_hold_code_%0d", i), {29'd0, x, y, z}, 32'd3);
    end
    btn_avancar = 1'b0;
    step(12);
    check("pedido_after_release", {29'd0, x, y, z}, 32'd3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("ack_pv", {31'd0, pedido_valido}, 32'd0);
    check("ack_code", {29'd0, x, y, z}, 32'd0);
    check("ack_entrada", {31'd0, entrada}, 32'd0);

    // Short glitches must never produce an event (checked from OCIOSO).
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_avancar = 1'b1;
      for (int k = 0; k < 3; k++) begin step(1); seen |= entrada; end
      btn_avancar = 1'b0;
      for (int k = 0; k < 3; k++) begin step(1); seen |= entrada; end
    end
    step(8);
    seen |= entrada;
    check("glitch_no_event", {31'd0, seen}, 32'd0);
    check("glitch_code", {29'd0, x, y, z}, 32'd0);

    // Confirm and cancel together: cancel wins.
    press(0);
    check("sim_enter_sel", {31'd0, entrada}, 32'd1);
    seen = 1'b0;
    btn_confirmar = 1'b1;
    btn_cancelar = 1'b1;
    for (int k = 0; k < 12; k++) begin step(1); seen |= pedido_valido; end
    btn_confirmar = 1'b0;
    btn_cancelar = 1'b0;
    for (int k = 0; k < 12; k++) begin step(1); seen |= pedido_valido; end
    check("sim_no_pedido", {31'd0, seen}, 32'd0);
    check("sim_to_ocioso", {31'd0, entrada}, 32'd0);

    // Timeout: event at edge 7 after the press, abandon 32 edges later (edge 39).
    btn_avancar = 1'b1;
    step(8);
    check("tmo_enter", {31'd0, entrada}, 32'd1);
    btn_avancar = 1'b0;
    step(29);
    check("tmo_not_yet", {31'd0, entrada}, 32'd1);
    step(3);
    check("tmo_expired", {31'd0, entrada}, 32'd0);
    check("tmo_code", {29'd0, x, y, z}, 32'd0);

    // Reset in PEDIDO with a button held.
    press(0);
    press(0);
    press(1);
    check("rst_pre_pv", {31'd0, pedido_valido}, 32'd1);
    check("rst_pre_code", {29'd0, x, y, z}, 32'd1);
    btn_avancar = 1'b1;
    step(3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_pv", {31'd0, pedido_valido}, 32'd0);
    check("rst_async_entrada", {31'd0, entrada}, 32'd0);
    check("rst_async_code", {29'd0, x, y, z}, 32'd0);
    step(2);
    reset = 1'b0;
    ack = 1'b1;
    step(4);
    ack = 1'b0;
    check("rst_ack_ignored", {31'd0, pedido_valido}, 32'd0);
    check("rst_held_early", {31'd0, entrada}, 32'd0);
    step(6);
    check("rst_held_repress", {31'd0, entrada}, 32'd1);
    check("rst_held_code", {29'd0, x, y, z}, 32'd0);
    btn_avancar = 1'b0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
